// File: rtl/rr_priority_encoder.sv
// Registered priority encoder: highest-set-bit-wins, optional round-robin
// rotation, and a valid/ready output stage that holds its result under back-pressure.
module rr_priority_encoder #(
  parameter int SIZE = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [2**SIZE-1:0]   req_i,
  input  logic                 rr_en_i,
  input  logic                 ready_i,
  output logic [SIZE-1:0]      idx_o,
  output logic [2**SIZE-1:0]   onehot_o,
  output logic                 valid_o
);

  localparam int N = 2**SIZE;

  typedef logic [SIZE-1:0] idx_t;
  typedef logic [N-1:0]    vec_t;

  function automatic idx_t f_highest(input vec_t v);
    idx_t r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = idx_t'(i);
    end
    return r;
  endfunction

  idx_t r_ptr;
  idx_t r_idx;
  vec_t r_onehot;
  logic r_valid;

  idx_t w_eff_ptr;
  vec_t w_low_mask;
  vec_t w_masked;
  idx_t w_win;
  logic w_any;
  logic w_load;

  // Two-pass search: bits below the pointer first, then the whole vector.
  // When the lower pass is empty, the highest bit overall is necessarily >= ptr.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_eff_ptr  = '0;
    w_low_mask = '0;
    w_masked   = '0;
    w_win      = '0;
    if (rr_en_i) w_eff_ptr = r_ptr;
    w_low_mask = ~({N{1'b1}} << w_eff_ptr);
    w_masked   = req_i & w_low_mask;
    if (|w_masked) w_win = f_highest(w_masked);
    else           w_win = f_highest(req_i);
  end

  assign w_any  = |req_i;
  assign w_load = !r_valid || ready_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is asynchronous on the falling rst_ni.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_valid  <= 1'b1;
        r_idx    <= w_win;
        r_onehot <= vec_t'(1) << w_win;
        if (rr_en_i) r_ptr <= w_win;
      end else begin
        r_valid  <= 1'b0;
        r_idx    <= '0;
        r_onehot <= '0;
      end
    end
  end

  assign valid_o  = r_valid;
  assign idx_o    = r_idx;
  assign onehot_o = r_onehot;

endmodule
